// File: rtl/mem_block_mover.sv
// Block copy/fill engine for the 16-bit data memory port.
// A small FSM walks src/dst word addresses and drives the shared address/read/write port.
module mem_block_mover #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_done,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    // Request fields captured at start; addresses are held word-aligned.
    typedef struct packed {
        logic              fill;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] pattern;
    } req_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    state_t            state, state_nxt;
    req_t              req_q;
    logic [CNT_W-1:0]  remain_q;
    logic [CNT_W-1:0]  words_done_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            req_q        <= '0;
            remain_q     <= '0;
            words_done_q <= '0;
            data_q       <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        req_q.fill    <= mode;
                        req_q.src     <= src_addr & ADDR_ALIGN;
                        req_q.dst     <= dst_addr & ADDR_ALIGN;
                        req_q.pattern <= fill_value;
                        remain_q      <= word_count;
                        words_done_q  <= '0;
                    end
                end
                S_READ: begin
                    data_q    <= mem_read_data;
                    req_q.src <= req_q.src + ADDR_STEP;
                end
                S_WRITE: begin
                    // The write in this cycle always lands, even when aborting,
                    // so it is always counted.
                    req_q.dst    <= req_q.dst + ADDR_STEP;
                    remain_q     <= remain_q - CNT_ONE;
                    words_done_q <= words_done_q + CNT_ONE;
                end
                S_DONE: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt       = state;
        busy            = 1'b0;
        done            = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0) state_nxt = S_DONE;
                    else if (mode)        state_nxt = S_WRITE;
                    else                  state_nxt = S_READ;
                end
            end
            S_READ: begin
                busy            = 1'b1;
                mem_read        = 1'b1;
                mem_access_addr = req_q.src;
                state_nxt       = abort ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                busy            = 1'b1;
                mem_write_en    = 1'b1;
                mem_access_addr = req_q.dst;
                mem_write_data  = req_q.fill ? req_q.pattern : data_q;
                if (abort)                      state_nxt = S_IDLE;
                else if (remain_q == CNT_ONE)   state_nxt = S_DONE;
                else if (req_q.fill)            state_nxt = S_WRITE;
                else                            state_nxt = S_READ;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural memory, expected-write scoreboard and directed transfers.
module tb_mem_block_mover;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [8:0]  word_count;
    logic [15:0] fill_value;
    logic        abort;
    logic        busy;
    logic        done;
    logic [8:0]  words_done;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;

    logic [15:0] mem [256];
    logic        tb_we;
    logic [7:0]  tb_waddr;
    logic [15:0] tb_wdata;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rd = 0;
    int          n_wr = 0;

    always #5 clk = ~clk;

    mem_block_mover dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .word_count     (word_count),
        .fill_value     (fill_value),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .words_done     (words_done),
        .mem_access_addr(mem_access_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    // Memory responder: combinational read, write on the rising edge.
    assign mem_read_data = mem_read ? mem[mem_access_addr[8:1]] : 16'h0000;
    always @(posedge clk) begin
        if (mem_write_en)  mem[mem_access_addr[8:1]] <= mem_write_data;
        else if (tb_we)    mem[tb_waddr] <= tb_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every DUT write must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (mem_read)     n_rd++;
        if (mem_write_en) n_wr++;
        if (mem_read || mem_write_en)
            chk("rd_wr_exclusive", 32'(mem_read & mem_write_en), 32'h0);
        if (mem_write_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_access_addr, mem_write_data}, 32'hFFFF_FFFF);
            end else begin
                chk("write_addr_data", {mem_access_addr, mem_write_data}, exp_q.pop_front());
            end
        end
    end

    task automatic preload(input logic [15:0] byte_addr, input logic [15:0] val);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_waddr = byte_addr[8:1];
        tb_wdata = val;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Issues one request and follows it until done or until the DUT drops busy.
    task automatic run(input logic m, input logic [15:0] s, input logic [15:0] d,
                       input logic [8:0] n, input logic [15:0] f,
                       input int poke_at, input int abort_at, input int reset_at,
                       output int done_rel, output int busy_cyc);
        bit finished = 0;
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; word_count = n; fill_value = f; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        done_rel = 0;
        busy_cyc = 0;
        for (int rel = 1; rel <= 600; rel++) begin
            if (busy) busy_cyc++;
            if (done) begin done_rel = rel; finished = 1; break; end
            if (rel > 1 && !busy) begin finished = 1; break; end
            abort = (rel == abort_at);
            reset = (rel == reset_at);
            start = (rel == poke_at);
            if (rel == poke_at) begin
                mode = ~m; src_addr = 16'h0010; dst_addr = 16'h0080; word_count = 9'd1;
            end
            @(negedge clk);
        end
        if (!finished) chk("xfer_timeout", 32'h0, 32'h1);
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int dr, bc, rd0, wr0;
        reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        word_count = '0; fill_value = '0; abort = 1'b0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_words_done", 32'(words_done), 32'h0);
        chk("reset_mem_outs", {mem_access_addr, mem_write_data}, 32'h0);
        chk("reset_mem_en", 32'({mem_read, mem_write_en}), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) preload(16'(i * 2), 16'hE000 | 16'(i));
        preload(16'h0010, 16'h1111); preload(16'h0012, 16'h2222);
        preload(16'h0014, 16'h3333); preload(16'h0016, 16'h4444);

        // Copy of 4 words
        exp_wr(16'h0040, 16'h1111); exp_wr(16'h0042, 16'h2222);
        exp_wr(16'h0044, 16'h3333); exp_wr(16'h0046, 16'h4444);
        run(1'b0, 16'h0010, 16'h0040, 9'd4, 16'h0, 0, 0, 0, dr, bc);
        chk("copy_done_cycle", 32'(dr), 32'd9);
        chk("copy_busy_cycles", 32'(bc), 32'd8);
        chk("copy_words_done", 32'(words_done), 32'd4);
        chk("copy_mem_dst3", 32'(mem[8'h23]), 32'h4444);

        // Fill with unaligned destination
        exp_wr(16'h0020, 16'hBEEF); exp_wr(16'h0022, 16'hBEEF); exp_wr(16'h0024, 16'hBEEF);
        run(1'b1, 16'h0000, 16'h0021, 9'd3, 16'hBEEF, 0, 0, 0, dr, bc);
        chk("fill_done_cycle", 32'(dr), 32'd4);
        chk("fill_words_done", 32'(words_done), 32'd3);
        chk("fill_mem_0020", 32'(mem[8'h10]), 32'hBEEF);
        chk("fill_mem_0026_untouched", 32'(mem[8'h13]), 32'hE013);

        // Zero count
        rd0 = n_rd; wr0 = n_wr;
        run(1'b0, 16'h0010, 16'h0050, 9'd0, 16'h0, 0, 0, 0, dr, bc);
        chk("zero_done_cycle", 32'(dr), 32'd1);
        chk("zero_busy_cycles", 32'(bc), 32'd0);
        chk("zero_no_mem_access", 32'((n_rd - rd0) + (n_wr - wr0)), 32'd0);
        chk("zero_words_done", 32'(words_done), 32'd0);

        // Fill of 4 with a second start mid-transfer
        for (int i = 0; i < 4; i++) exp_wr(16'h0060 + 16'(2 * i), 16'h1234);
        run(1'b1, 16'h0000, 16'h0060, 9'd4, 16'h1234, 2, 0, 0, dr, bc);
        chk("ignore_start_done_cycle", 32'(dr), 32'd5);
        chk("ignore_start_words_done", 32'(words_done), 32'd4);

        // Address wrap
        exp_wr(16'hFFFC, 16'hC0DE); exp_wr(16'hFFFE, 16'hC0DE); exp_wr(16'h0000, 16'hC0DE);
        run(1'b1, 16'h0000, 16'hFFFC, 9'd3, 16'hC0DE, 0, 0, 0, dr, bc);
        chk("wrap_done_cycle", 32'(dr), 32'd4);
        chk("wrap_words_done", 32'(words_done), 32'd3);
        chk("wrap_mem_0000", 32'(mem[8'h00]), 32'hC0DE);

        // Abort sampled in the 3rd WRITE cycle (cycle k+6)
        exp_wr(16'h0090, 16'h1111); exp_wr(16'h0092, 16'h2222); exp_wr(16'h0094, 16'h3333);
        run(1'b0, 16'h0010, 16'h0090, 9'd8, 16'h0, 0, 6, 0, dr, bc);
        chk("abort_no_done", 32'(dr), 32'd0);
        chk("abort_words_done", 32'(words_done), 32'd3);
        chk("abort_idle", 32'(busy), 32'h0);
        chk("abort_mem_0096_untouched", 32'(mem[8'h4B]), 32'hE04B);

        // Reset sampled in the 3rd READ cycle (cycle k+5)
        exp_wr(16'h00A0, 16'h1111); exp_wr(16'h00A2, 16'h2222);
        run(1'b0, 16'h0010, 16'h00A0, 9'd8, 16'h0, 0, 0, 5, dr, bc);
        chk("rst_mid_done", 32'({busy, done}), 32'h0);
        chk("rst_mid_words_done", 32'(words_done), 32'h0);
        chk("rst_mid_mem_outs", {mem_access_addr, mem_write_data}, 32'h0);
        chk("rst_mid_mem_en", 32'({mem_read, mem_write_en}), 32'h0);
        reset = 1'b0;

        // Overlapping forward copy
        preload(16'h0100, 16'hA5A5);
        exp_wr(16'h0102, 16'hA5A5); exp_wr(16'h0104, 16'hA5A5); exp_wr(16'h0106, 16'hA5A5);
        run(1'b0, 16'h0100, 16'h0102, 9'd3, 16'h0, 0, 0, 0, dr, bc);
        chk("overlap_done_cycle", 32'(dr), 32'd7);
        chk("overlap_mem_0106", 32'(mem[8'h83]), 32'hA5A5);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
